// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared pipeline constants and the next-PC select type
package instruction_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP,
    PC_HOLD
  } pc_sel_t;

  // Instruction addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-stage signal bundle between fetch, decode, hazard unit and imem
interface instruction_fetch_if;

  logic        stallInput;
  logic        branchControlInput;
  logic [31:0] pcBranchInput;
  logic        jumpInput;
  logic [31:0] pcJumpInput;
  logic        ifFlushInput;
  logic [31:0] imemAddressOutput;
  logic [31:0] imemDataInput;
  logic [31:0] instructionOutput;
  logic [31:0] pc4Output;
  logic        validOutput;
  logic [31:0] fetchCountOutput;

  // master: the fetch stage itself
  modport master (
    input  stallInput, branchControlInput, pcBranchInput, jumpInput, pcJumpInput,
    input  ifFlushInput, imemDataInput,
    output imemAddressOutput, instructionOutput, pc4Output, validOutput, fetchCountOutput
  );

  // slave: the surrounding pipeline (decode, hazard unit, instruction memory)
  modport slave (
    output stallInput, branchControlInput, pcBranchInput, jumpInput, pcJumpInput,
    output ifFlushInput, imemDataInput,
    input  imemAddressOutput, instructionOutput, pc4Output, validOutput, fetchCountOutput
  );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// rtl/instruction_fetch_if_id_register.sv - IF/ID pipeline register with reset > stall > flush priority
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instruction,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset || (!stall && flush)) begin
      instruction <= NOP_WORD;
      pc4         <= 32'd0;
      valid       <= 1'b0;
    end else if (!stall) begin
      instruction <= instruction_in;
      pc4         <= pc4_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS IF stage: PC register, next-PC select, fetch counter, IF/ID register
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic [31:0] fetch_count;
  logic        load_valid;
  pc_sel_t     pc_sel;

  assign pc4                   = pc + 32'd4;
  assign bus.imemAddressOutput = pc;
  assign bus.fetchCountOutput  = fetch_count;

  // Stall overrides redirects: decode is held and re-resolves next cycle.
  always_comb begin
    pc_sel = PC_SEQ;
    if (bus.stallInput)              pc_sel = PC_HOLD;
    else if (bus.jumpInput)          pc_sel = PC_JUMP;
    else if (bus.branchControlInput) pc_sel = PC_BRANCH;
  end

  always_comb begin
    pc_next = pc4;
    case (pc_sel)
      PC_HOLD:   pc_next = pc;
      PC_JUMP:   pc_next = align_word(bus.pcJumpInput);
      PC_BRANCH: pc_next = align_word(bus.pcBranchInput);
      default:   pc_next = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= align_word(RESET_PC);
    else       pc <= pc_next;
  end

  assign load_valid = !bus.stallInput && !bus.ifFlushInput;

  always_ff @(posedge clk) begin
    if (reset)           fetch_count <= 32'd0;
    else if (load_valid) fetch_count <= fetch_count + 32'd1;
  end

  if_id_register #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .stall         (bus.stallInput),
    .flush         (bus.ifFlushInput),
    .instruction_in(bus.imemDataInput),
    .pc4_in        (pc4),
    .instruction   (bus.instructionOutput),
    .pc4           (bus.pc4Output),
    .valid         (bus.validOutput)
  );

endmodule
